// File: rtl/instr_loader_if.sv
`default_nettype none
// ---- instr_loader_if : byte-in / word-write bus between UART path, loader and instruction memory, rev 1.0 ----
interface instr_loader_if #(
  parameter int NB_BYTE  = 8,
  parameter int NB_INSTR = 32,
  parameter int NB_ADDR  = 8
);
  logic                i_start;
  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic                o_wr_en;
  logic [NB_ADDR-1:0]  o_wr_addr;
  logic [NB_INSTR-1:0] o_wr_data;
  logic                o_busy;
  logic                o_done;
  logic                o_overflow;

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow
  );

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ---- instr_loader : assembles big-endian instruction words from a byte stream and writes them, rev 1.0 ----
module instr_loader #(
  parameter int                  NB_BYTE   = 8,
  parameter int                  NB_INSTR  = 32,
  parameter int                  NB_ADDR   = 8,
  parameter logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  instr_loader_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [1:0]          next_state;
  logic [1:0]          byte_cnt;
  logic [NB_ADDR-1:0]  word_addr;
  logic [NB_INSTR-1:0] asm_word;
  logic [NB_INSTR-1:0] next_word;
  logic                wr_en;
  logic [NB_ADDR-1:0]  wr_addr;
  logic [NB_INSTR-1:0] wr_data;
  logic                overflow;
  logic                busy;
  logic                done;
  logic                last_byte;
  logic                is_halt;
  logic                at_last;
  logic                restart;

  assign next_word = {asm_word[NB_INSTR-NB_BYTE-1:0], bus.i_rx_data};
  assign last_byte = (state == S_LOAD) && bus.i_rx_valid && (byte_cnt == 2'd3);
  assign is_halt   = (next_word == HALT_WORD);
  assign at_last   = (word_addr == {NB_ADDR{1'b1}});
  // i_start only counts outside LOAD; a partial word survives a stray start
  assign restart   = bus.i_start && (state != S_LOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.i_start) next_state = S_LOAD;
      S_LOAD:  if (last_byte && (is_halt || at_last)) next_state = S_DONE;
      S_DONE:  if (bus.i_start) next_state = S_LOAD;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_LOAD:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_cnt  <= 2'd0;
      word_addr <= '0;
      asm_word  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (state == S_IDLE || restart) begin
        byte_cnt  <= 2'd0;
        word_addr <= '0;
        asm_word  <= '0;
        overflow  <= 1'b0;
      end else if (state == S_LOAD && bus.i_rx_valid) begin
        asm_word <= next_word;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          wr_en     <= 1'b1;
          wr_addr   <= word_addr;
          wr_data   <= next_word;
          word_addr <= word_addr + 1'b1;
          if (!is_halt && at_last) overflow <= 1'b1;
        end
      end
    end
  end

  assign bus.o_wr_en     = wr_en;
  assign bus.o_wr_addr   = wr_addr;
  assign bus.o_wr_data   = wr_data;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_overflow  = overflow;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ---- tb_instr_loader : directed self-checking bench for instr_loader (4-word memory), rev 1.0 ----
module tb_instr_loader;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   wr_count;

  instr_loader_if #(.NB_ADDR(2)) bus ();

  instr_loader #(.NB_ADDR(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_wr_en === 1'b1) wr_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    step();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_done, bus.o_overflow} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%0b addr=%0d data=%h busy=%0b done=%0b ovf=%0b exp all 0",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_done, bus.o_overflow);
    end
  endtask

  task automatic test_halt_load();
    int base;
    base = wr_count;
    send_word(32'h1234_5678);
    step();
    checks++;
    if (wr_count != base) begin
      errors++; $display("FAIL idle_bytes_ignored got %0d writes exp 0", wr_count - base);
    end
    pulse_start();
    checks++;
    if ({bus.o_busy, bus.o_done} !== 2'b10) begin
      errors++; $display("FAIL start_busy got busy=%0b done=%0b exp 1 0", bus.o_busy, bus.o_done);
    end
    send_word(32'h2008_0005);
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 2'd0, 32'h2008_0005}) begin
      errors++; $display("FAIL halt_w0 got en=%0b addr=%0d data=%h exp 1 0 20080005", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
    end
    send_word(32'hFFFF_FFFF);
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 2'd1, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL halt_w1 got en=%0b addr=%0d data=%h exp 1 1 ffffffff", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
    end
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_overflow} !== 3'b010) begin
      errors++; $display("FAIL halt_status got busy=%0b done=%0b ovf=%0b exp 0 1 0", bus.o_busy, bus.o_done, bus.o_overflow);
    end
    step();
    checks++;
    if ({bus.o_wr_en, bus.o_done} !== 2'b01) begin
      errors++; $display("FAIL halt_after got en=%0b done=%0b exp 0 1", bus.o_wr_en, bus.o_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b2b [8];
    logic        exp_en;
    logic [31:0] exp_data;
    b2b = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h8C, 8'h01, 8'h00, 8'h04};
    pulse_start();
    checks++;
    if ({bus.o_busy, bus.o_done} !== 2'b10) begin
      errors++; $display("FAIL done_falls got busy=%0b done=%0b exp 1 0", bus.o_busy, bus.o_done);
    end
    for (int i = 0; i < 8; i++) begin
      send_byte(b2b[i]);
      exp_en   = (i == 3) || (i == 7);
      exp_data = (i == 3) ? 32'h0000_0020 : 32'h8C01_0004;
      checks++;
      if (bus.o_wr_en !== exp_en) begin
        errors++; $display("FAIL b2b_en byte%0d got %0b exp %0b", i, bus.o_wr_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if ({bus.o_wr_addr, bus.o_wr_data} !== {((i == 3) ? 2'd0 : 2'd1), exp_data}) begin
          errors++; $display("FAIL b2b_word byte%0d got addr=%0d data=%h exp data %h", i, bus.o_wr_addr, bus.o_wr_data, exp_data);
        end
      end
    end
  endtask

  task automatic test_start_in_load();
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    checks++;
    if ({bus.o_busy, bus.o_wr_en} !== 2'b10) begin
      errors++; $display("FAIL start_in_load got busy=%0b en=%0b exp 1 0", bus.o_busy, bus.o_wr_en);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 2'd2, 32'h1122_3344}) begin
      errors++; $display("FAIL partial_kept got en=%0b addr=%0d data=%h exp 1 2 11223344", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] words [4];
    int          base;
    words = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
    // finish the previous load at addr 3 with a non-HALT word
    send_word(32'hAABB_CCDD);
    checks++;
    if ({bus.o_wr_addr, bus.o_overflow, bus.o_done} !== {2'd3, 2'b11}) begin
      errors++; $display("FAIL ovf_first got addr=%0d ovf=%0b done=%0b exp 3 1 1", bus.o_wr_addr, bus.o_overflow, bus.o_done);
    end
    pulse_start();
    checks++;
    if ({bus.o_overflow, bus.o_busy} !== 2'b01) begin
      errors++; $display("FAIL ovf_cleared got ovf=%0b busy=%0b exp 0 1", bus.o_overflow, bus.o_busy);
    end
    for (int i = 0; i < 4; i++) begin
      send_word(words[i]);
      checks++;
      if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 2'(i), words[i]}) begin
        errors++; $display("FAIL ovf_w%0d got en=%0b addr=%0d data=%h exp addr %0d data %h", i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, i, words[i]);
      end
    end
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_overflow} !== 3'b011) begin
      errors++; $display("FAIL ovf_status got busy=%0b done=%0b ovf=%0b exp 0 1 1", bus.o_busy, bus.o_done, bus.o_overflow);
    end
    step();
    base = wr_count;
    send_word(32'hFFFF_FFFF);
    send_word(32'h1357_9BDF);
    step();
    checks++;
    if (wr_count != base || bus.o_done !== 1'b1) begin
      errors++; $display("FAIL done_bytes_ignored got %0d writes done=%0b exp 0 1", wr_count - base, bus.o_done);
    end
  endtask

  task automatic test_halt_last();
    pulse_start();
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0003);
    send_word(32'hFFFF_FFFF);
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_done, bus.o_overflow} !== {1'b1, 2'd3, 2'b10}) begin
      errors++; $display("FAIL halt_last got en=%0b addr=%0d done=%0b ovf=%0b exp 1 3 1 0", bus.o_wr_en, bus.o_wr_addr, bus.o_done, bus.o_overflow);
    end
  endtask

  task automatic test_reset_midload();
    int base;
    pulse_start();
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_done, bus.o_overflow} !== 38'd0) begin
      errors++; $display("FAIL async_reset got en=%0b data=%h busy=%0b done=%0b exp all 0", bus.o_wr_en, bus.o_wr_data, bus.o_busy, bus.o_done);
    end
    step();
    rst_n = 1'b1;
    step();
    pulse_start();
    base = wr_count;
    send_word(32'h3C01_1234);
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 2'd0, 32'h3C01_1234}) begin
      errors++; $display("FAIL after_reset got en=%0b addr=%0d data=%h exp 1 0 3c011234", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
    end
    step();
    checks++;
    if (wr_count - base != 1) begin
      errors++; $display("FAIL after_reset_count got %0d writes exp 1", wr_count - base);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    wr_count       = 0;
    rst_n          = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_halt_load();
    test_back_to_back();
    test_start_in_load();
    test_overflow();
    test_halt_last();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
# instr_loader

Byte-to-word program loader that fills the instruction memory feeding the pipeline fetch stage and, through it, the opcode/funct decoder. It accepts a serial stream of bytes (one strobe per byte, from the debug UART receive path), assembles big-endian 32-bit MIPS instruction words, and issues one registered write per word at consecutive word addresses. Loading stops on the HALT word or when memory is full. Completion and overflow are reported to the debug unit.

## Interface

Parameters:
- NB_BYTE, 8, width of an input byte.
- NB_INSTR, 32, instruction word width; must equal 4*NB_BYTE.
- NB_ADDR, 8, word-address width; memory depth is 2**NB_ADDR words.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program instruction.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse; arms a new load from address 0.
- i_rx_data  in  NB_BYTE  incoming byte.
- i_rx_valid  in  1  single-cycle strobe; i_rx_data is valid this cycle.
- o_wr_en  out  1  instruction-memory write enable, one cycle per word.
- o_wr_addr  out  NB_ADDR  word address of the current write.
- o_wr_data  out  NB_INSTR  assembled instruction word.
- o_busy  out  1  high while in LOAD.
- o_done  out  1  high in DONE; held until the next i_start.
- o_overflow  out  1  set when memory filled without HALT; cleared on i_start.

## Operation

- FSM states: IDLE, LOAD, DONE. Reset state: IDLE.
- IDLE:
  - i_start goes to LOAD.
  - Clears the byte counter (2 bits), the word address, o_overflow and the assembly register.
  - i_rx_valid is ignored.
- LOAD:
  - Each i_rx_valid shifts the byte in: asm <= {asm[23:0], i_rx_data}. The first byte received becomes bits [31:24].
  - When the 4th byte of a word is accepted, on that same edge:
    - o_wr_data <= {asm[23:0], i_rx_data}
    - o_wr_addr <= word address; o_wr_en <= 1 (for one cycle)
    - byte counter <= 0; word address increments
- Termination, decided on the 4th-byte edge:
  - If the assembled word equals HALT_WORD, it is still written, and the state goes to DONE.
  - Else, if the word address is 2**NB_ADDR-1 (the last location), the word is written, o_overflow <= 1, and the state goes to DONE.
  - HALT at the last address: DONE with o_overflow = 0.
- DONE:
  - i_rx_valid is ignored; o_done = 1.
  - i_start goes to LOAD and clears the address, byte counter and o_overflow.
- Boundary rules:
  - i_start while in LOAD: ignored; the partial word is kept.
  - A partial word (1-3 bytes) is never written.
  - Back-to-back i_rx_valid on every cycle is fully supported. The word write overlaps acceptance of the next word's first byte.
- Reset: asserting i_rst_n low mid-load immediately forces IDLE. All outputs go to 0. Memory contents already written are unaffected.

## Timing

- Reset value of every output: 0 (o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow).
- o_wr_en, o_wr_addr and o_wr_data are registered. They are valid in the cycle after the clock edge that samples the 4th-byte i_rx_valid.
- o_busy is high from the cycle after i_start until the cycle after the terminating write edge.
- o_done rises in the same cycle as the final o_wr_en pulse.
- o_done falls the cycle after i_start is sampled.
- Throughput: one word per 4 accepted bytes; no stall or back-pressure exists.

## Test plan

- Load 0x20,0x08,0x00,0x05 then FF,FF,FF,FF after i_start:
  - write 0x20080005 at addr 0, then 0xFFFFFFFF at addr 1;
  - o_done = 1, o_overflow = 0, o_busy = 0 afterward.
- Bytes on 8 consecutive cycles forming 0x00000020 and 0x8C010004: two o_wr_en pulses exactly 4 cycles apart, at addr 0 and 1, with correct data. No byte is lost.
- NB_ADDR=2, send 4 non-HALT words: writes at addr 0..3, then o_overflow = 1 and o_done = 1. Further bytes produce no o_wr_en.
- Send 2 bytes, assert i_rst_n low for 1 cycle, then i_start and 4 bytes 0x3C,0x01,0x12,0x34: a single write of 0x3C011234 at addr 0; no stale bytes.
- Bytes before i_start and during DONE: no o_wr_en. A second i_start restarts at addr 0 and clears o_overflow.
- i_start pulsed after 2 bytes of a word in LOAD: it is ignored. Completing the word writes it at the expected address.
